// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and op encodings for the HI/LO multiply/divide unit.
// The divide path is present only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  // Op codes driven by the control unit on the muldiv Op port
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FIXUP,
    ST_DONE
  } muldiv_state_t;

  // R-type funct field values that select the muldiv unit
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  function automatic muldiv_op_t funct_to_op(input logic [5:0] funct);
    muldiv_op_t op;
    case (funct)
      FUNCT_MULT:  op = OP_MULT;
      FUNCT_MULTU: op = OP_MULTU;
      FUNCT_DIV:   op = OP_DIV;
      FUNCT_DIVU:  op = OP_DIVU;
      default:     op = OP_MULT;
    endcase
    return op;
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring
// divide. The divide half (trial subtractor) exists only with MULDIV_DIV_EN.
//
// Multiply: acc = {partial product high, multiplier remnant}.
// Divide:   acc = {remainder, dividend/quotient}; the quotient bit is returned
//           separately and the accumulator LSB is left 0 for the caller to fill.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] mul_sum;

  // Conditional add of the multiplicand into the upper half, carry kept
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  // Shift remainder:quotient left by one and trial-subtract the divisor
  always_comb begin
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, operand};
  end

  // A successful trial is always below the divisor, so bit WIDTH is 0 then
  assign unused_trial_bit = trial[WIDTH];

  // Select the multiply or divide iteration result
  always_comb begin
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    q_bit    = 1'b0;
    if (is_div) begin
      q_bit    = ~trial[WIDTH+1];
      acc_next = {(q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], 1'b0};
    end
  end
`else
  // Multiply only; a divide op never reaches RUN in this build
  always_comb begin
    acc_next = is_div ? acc : {mul_sum, acc[WIDTH-1:1]};
    q_bit    = 1'b0;
  end
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multicycle HI/LO multiply/divide controller. Owns the FSM,
// iteration down-counter, sign latches, sign fixup and the HI/LO registers.
// Define MULDIV_DIV_EN to build the DIV/DIVU path; otherwise divide ops
// complete immediately with IllegalOp.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for Start; operands captured on the accepting edge
// ST_LOAD  | take magnitudes and signs, preload accumulator and counter
// ST_RUN   | one shift-add / restoring-divide iteration per cycle, WIDTH cycles
// ST_FIXUP | apply result signs, write HI/LO
// ST_DONE  | Done pulse; HI/LO valid
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivZero,
  output logic             IllegalOp
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  muldiv_state_t      state, state_next;
  muldiv_op_t         op_q;
  logic [WIDTH-1:0]   a_raw, b_raw, operand;
  logic [WIDTH-1:0]   a_load, b_load;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic               q_bit;
  logic [CW-1:0]      count;
  logic               sign_a, sign_b;
  logic               is_div, is_signed;
  logic               load_abort;
  logic               abort_flag;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);

`ifdef MULDIV_DIV_EN
  assign load_abort = is_div && (b_raw == '0);
  assign DivZero    = abort_flag;
  assign IllegalOp  = 1'b0;
`else
  assign load_abort = is_div;
  assign DivZero    = 1'b0;
  assign IllegalOp  = abort_flag;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .is_div   (is_div),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  // Operand magnitudes for signed ops; unsigned ops pass through raw
  always_comb begin
    a_load = (is_signed && a_raw[WIDTH-1]) ? -a_raw : a_raw;
    b_load = (is_signed && b_raw[WIDTH-1]) ? -b_raw : b_raw;
  end

  // Sign fixup of the finished magnitude result
  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      if (sign_a ^ sign_b) fix_lo = -acc[WIDTH-1:0];
      if (sign_a)          fix_hi = -acc[2*WIDTH-1:WIDTH];
    end else
`endif
    if (sign_a ^ sign_b) {fix_hi, fix_lo} = -acc;
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (Start) state_next = ST_LOAD;
      ST_LOAD:  state_next = load_abort ? ST_DONE : ST_RUN;
      ST_RUN:   if (count == '0) state_next = ST_FIXUP;
      ST_FIXUP: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Operand capture, iteration datapath, counter and HI/LO write
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q    <= OP_MULT;
      a_raw   <= '0;
      b_raw   <= '0;
      operand <= '0;
      acc     <= '0;
      count   <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            op_q  <= muldiv_op_t'(Op);
            a_raw <= A;
            b_raw <= B;
          end
        end
        ST_LOAD: begin
          sign_a  <= is_signed & a_raw[WIDTH-1];
          sign_b  <= is_signed & b_raw[WIDTH-1];
          operand <= b_load;
          acc     <= {{WIDTH{1'b0}}, a_load};
          count   <= CNT_LAST;
        end
        ST_RUN: begin
          acc <= {acc_next[2*WIDTH-1:1], acc_next[0] | q_bit};
          if (count != '0) count <= count - 1'b1;
        end
        ST_FIXUP: begin
          Hi <= fix_hi;
          Lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  // Registered status: aligned so each is high exactly in the target state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Busy       <= 1'b0;
      Done       <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      Busy       <= (state_next != ST_IDLE);
      Done       <= (state_next == ST_DONE);
      abort_flag <= (state == ST_LOAD) && load_abort;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors for muldiv_ctrl with a queue scoreboard.
// Divide vectors are selected by MULDIV_DIV_EN to match the DUT build.
module tb_muldiv_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivZero, IllegalOp;
  logic [31:0] Hi, Lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        ill;
    int          lat;
    int          start;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          done_seen = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .Hi        (Hi),
    .Lo        (Lo),
    .DivZero   (DivZero),
    .IllegalOp (IllegalOp)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done pulse consumes one expectation
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got Done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("hi",         64'(Hi),        64'(mon_e.hi));
        check("lo",         64'(Lo),        64'(mon_e.lo));
        check("divzero",    64'(DivZero),   64'(mon_e.dz));
        check("illegalop",  64'(IllegalOp), 64'(mon_e.ill));
        check("busy_done",  64'(Busy),      64'd1);
        check("latency",    64'(cyc - mon_e.start), 64'(mon_e.lat));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo,
                      input logic edz, input logic eill, input int lat, input bit sync = 1'b1);
    exp_t e;
    if (sync) begin
      @(posedge Clk); #1;
    end
    Start = 1'b1; Op = op; A = a; B = b;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.ill = eill; e.lat = lat; e.start = cyc;
    sb.push_back(e);
    check("busy_c0", 64'(Busy), 64'd0);
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic send_norm(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo);
    model_hi = ehi;
    model_lo = elo;
    send(op, a, b, ehi, elo, 1'b0, 1'b0, 35);
  endtask

  task automatic send_abort(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic edz, input logic eill);
    send(op, a, b, model_hi, model_lo, edz, eill, 2);
  endtask

  task automatic wait_done();
    int n0;
    bit seen;
    n0 = done_seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk); #1;
      if (done_seen > n0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no Done expected Done within 100 cycles");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    64'(Busy),      64'd0);
    check({tag, "_done"},    64'(Done),      64'd0);
    check({tag, "_hi"},      64'(Hi),        64'd0);
    check({tag, "_lo"},      64'(Lo),        64'd0);
    check({tag, "_divzero"}, 64'(DivZero),   64'd0);
    check({tag, "_illegal"}, 64'(IllegalOp), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    repeat (3) @(posedge Clk);
    #1 check_all_zero("reset");
    Reset = 1'b0;

    // MULTU max*max with Busy profile over cycles 1..36
    send_norm(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    for (int k = 1; k <= 36; k++) begin
      @(negedge Clk);
      check("busy_profile", 64'(Busy), (k <= 35) ? 64'd1 : 64'd0);
    end

    send_norm(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_done();
    send_norm(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    wait_done();
    send_norm(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    wait_done();
    send_norm(2'b01, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800);
    wait_done();

    // MULT with Start re-pulsed in cycles 5 and 20; must be ignored
    send_norm(2'b00, 32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC);
    repeat (4) @(posedge Clk);
    #1 Start = 1'b1; Op = 2'b11; A = 32'd5; B = 32'd0;
    check("busy_c5", 64'(Busy), 64'd1);
    @(posedge Clk); #1 Start = 1'b0;
    repeat (14) @(posedge Clk);
    #1 Start = 1'b1; Op = 2'b01; A = 32'd9; B = 32'd9;
    @(posedge Clk); #1 Start = 1'b0;
    wait_done();
    repeat (4) @(posedge Clk);

`ifdef MULDIV_DIV_EN
    send_norm(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done();
    send_norm(2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
    wait_done();
    send_norm(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    wait_done();
    send_norm(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    wait_done();
    send_norm(2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF);
    wait_done();
    send_abort(2'b11, 32'd5, 32'd0, 1'b1, 1'b0);
    wait_done();
    send_abort(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0);
    wait_done();
`else
    send_abort(2'b11, 32'd5, 32'd0, 1'b0, 1'b1);
    wait_done();
    send_abort(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    wait_done();
`endif

    // Reset in cycle 10 of a MULT, then restart in the first post-reset cycle
    @(posedge Clk); #1;
    Start = 1'b1; Op = 2'b00; A = 32'h0000_1234; B = 32'h0000_5678;
    @(posedge Clk); #1 Start = 1'b0;
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;
    #1 check_all_zero("midreset");
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd12;
    send(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 35, 1'b0);
    wait_done();

    repeat (5) @(posedge Clk);
    check("pending_left", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
